// File: rtl/ipf_res_buf_if.sv
// ipf_res_buf_if: control, capture and drain signals of the IPF result buffer.
// The master drives the capture strobe and the drain handshake; the slave is the buffer.
interface ipf_res_buf_if #(
  parameter int Res_Width  = 1152,
  parameter int Addr_Width = 6
);
  logic                  clr;
  logic                  wrap_en;
  logic                  res_valid;
  logic [Res_Width-1:0]  res;
  logic                  drain_start;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [Res_Width-1:0]  rd_data;
  logic                  rd_last;
  logic                  rd_perr;
  logic [Addr_Width:0]   count;
  logic                  full;
  logic                  ovf;
  logic                  done;

  modport master (
    output clr, wrap_en, res_valid, res, drain_start, rd_ready,
    input  rd_valid, rd_data, rd_last, rd_perr, count, full, ovf, done
  );

  modport slave (
    input  clr, wrap_en, res_valid, res, drain_start, rd_ready,
    output rd_valid, rd_data, rd_last, rd_perr, count, full, ovf, done
  );
endinterface

// File: rtl/ipf_res_buf.sv
// ipf_res_buf: captures IPF result words into a circular buffer and drains them
// oldest-first over a valid/ready port with a last-word marker.
// Optional feature macro: IPF_RES_BUF_PARITY_EN adds one XOR parity bit per entry,
// checked on read and reported on rd_perr.
module ipf_res_buf #(
  parameter int Res_Width  = 1152,
  parameter int Depth      = 64,
  parameter int Addr_Width = 6
) (
  input  logic         clk,
  input  logic         rst,
  ipf_res_buf_if.slave bus
);

  localparam int Cnt_Width = Addr_Width + 1;
  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [Addr_Width:0]   Cnt_Depth = Cnt_Width'(Depth);
  localparam logic [Addr_Width:0]   Cnt_Zero  = {Cnt_Width{1'b0}};
  localparam logic [Addr_Width:0]   Cnt_One   = {{Addr_Width{1'b0}}, 1'b1};
  localparam logic [Addr_Width:0]   Cnt_Two   = Cnt_Width'(2);
  localparam logic [Addr_Width-1:0] Ptr_One   = {{(Addr_Width-1){1'b0}}, 1'b1};

`ifdef IPF_RES_BUF_PARITY_EN
  localparam int Mem_Width = Res_Width + 1;
`else
  localparam int Mem_Width = Res_Width;
`endif

  function automatic logic parity_f(input logic [Res_Width-1:0] data);
    return ^data;
  endfunction

  logic [Mem_Width-1:0]  mem_r [Depth];
  logic [1:0]            state_r, state_nxt;
  logic [Addr_Width-1:0] wr_ptr_r, wr_ptr_nxt;
  logic [Addr_Width-1:0] rd_ptr_r, rd_ptr_nxt;
  logic [Addr_Width:0]   count_r, count_nxt;
  logic                  full_r;
  logic                  ovf_r, ovf_nxt;
  logic                  done_r, done_nxt;
  logic                  rd_valid_r;
  logic [Res_Width-1:0]  rd_data_r;
  logic                  rd_last_r;
  logic                  rd_perr_r;
  logic                  mem_we_s;
  logic                  load_s;
  logic                  xfer_s;
  logic [Mem_Width-1:0]  wr_word_s;
  logic [Mem_Width-1:0]  rd_word_s;
  logic                  rd_perr_s;

`ifdef IPF_RES_BUF_PARITY_EN
  assign wr_word_s = {parity_f(bus.res), bus.res};
  assign rd_perr_s = rd_word_s[Res_Width] != parity_f(rd_word_s[Res_Width-1:0]);
`else
  assign wr_word_s = bus.res;
  assign rd_perr_s = 1'b0;
`endif

  // Prefetch address: the entry that becomes current after this cycle's load or transfer.
  assign rd_word_s = mem_r[rd_ptr_nxt];

  // Next-state, pointer, occupancy and overflow decisions for the capture/drain FSM.
  always_comb begin
    state_nxt  = state_r;
    wr_ptr_nxt = wr_ptr_r;
    rd_ptr_nxt = rd_ptr_r;
    count_nxt  = count_r;
    ovf_nxt    = ovf_r;
    done_nxt   = done_r;
    mem_we_s   = 1'b0;
    load_s     = 1'b0;
    xfer_s     = 1'b0;
    case (state_r)
      S_FILL: begin
        if (bus.res_valid) begin
          if (count_r != Cnt_Depth) begin
            mem_we_s   = 1'b1;
            wr_ptr_nxt = wr_ptr_r + Ptr_One;
            count_nxt  = count_r + Cnt_One;
          end else if (bus.wrap_en) begin
            // Full and wrapping: the new word replaces the oldest one.
            mem_we_s   = 1'b1;
            wr_ptr_nxt = wr_ptr_r + Ptr_One;
            rd_ptr_nxt = rd_ptr_r + Ptr_One;
            ovf_nxt    = 1'b1;
          end else begin
            ovf_nxt    = 1'b1;
          end
        end else begin
          ovf_nxt = ovf_r;
        end
        if (bus.drain_start) begin
          if (count_nxt != Cnt_Zero) begin
            state_nxt = S_DRAIN;
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end else begin
          state_nxt = S_FILL;
        end
      end
      S_DRAIN: begin
        if (bus.res_valid) begin
          ovf_nxt = 1'b1;
        end else begin
          ovf_nxt = ovf_r;
        end
        if (!rd_valid_r) begin
          load_s = 1'b1;
        end else if (bus.rd_ready) begin
          xfer_s     = 1'b1;
          rd_ptr_nxt = rd_ptr_r + Ptr_One;
          count_nxt  = count_r - Cnt_One;
          if (count_r == Cnt_One) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
          end
        end else begin
          xfer_s = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.res_valid) begin
          ovf_nxt = 1'b1;
        end else begin
          ovf_nxt = ovf_r;
        end
      end
      default: begin
        state_nxt = S_FILL;
      end
    endcase
  end

  // Entry storage; contents are not reset and a clear suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we_s && !bus.clr) begin
      mem_r[wr_ptr_r] <= wr_word_s;
    end
  end

  // Control state and registered read port, reset asynchronously and cleared by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_FILL;
      wr_ptr_r   <= {Addr_Width{1'b0}};
      rd_ptr_r   <= {Addr_Width{1'b0}};
      count_r    <= Cnt_Zero;
      full_r     <= 1'b0;
      ovf_r      <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {Res_Width{1'b0}};
      rd_last_r  <= 1'b0;
      rd_perr_r  <= 1'b0;
    end else if (bus.clr) begin
      state_r    <= S_FILL;
      wr_ptr_r   <= {Addr_Width{1'b0}};
      rd_ptr_r   <= {Addr_Width{1'b0}};
      count_r    <= Cnt_Zero;
      full_r     <= 1'b0;
      ovf_r      <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {Res_Width{1'b0}};
      rd_last_r  <= 1'b0;
      rd_perr_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      wr_ptr_r <= wr_ptr_nxt;
      rd_ptr_r <= rd_ptr_nxt;
      count_r  <= count_nxt;
      full_r   <= (count_nxt == Cnt_Depth);
      ovf_r    <= ovf_nxt;
      done_r   <= done_nxt;
      if (load_s) begin
        rd_valid_r <= 1'b1;
        rd_data_r  <= rd_word_s[Res_Width-1:0];
        rd_last_r  <= (count_r == Cnt_One);
        rd_perr_r  <= rd_perr_s;
      end else if (xfer_s) begin
        if (count_r == Cnt_One) begin
          rd_valid_r <= 1'b0;
          rd_last_r  <= 1'b0;
          rd_perr_r  <= 1'b0;
        end else begin
          rd_valid_r <= 1'b1;
          rd_data_r  <= rd_word_s[Res_Width-1:0];
          rd_last_r  <= (count_r == Cnt_Two);
          rd_perr_r  <= rd_perr_s;
        end
      end
    end
  end

  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data  = rd_data_r;
  assign bus.rd_last  = rd_last_r;
  assign bus.rd_perr  = rd_perr_r;
  assign bus.count    = count_r;
  assign bus.full     = full_r;
  assign bus.ovf      = ovf_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_ipf_res_buf.sv
// tb_ipf_res_buf: directed vector table plus hand-written back-pressure, reset
// and (when IPF_RES_BUF_PARITY_EN is defined) parity sequences; Depth=4, Res_Width=16.
module tb_ipf_res_buf;
  localparam int RW = 16;
  localparam int DP = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ipf_res_buf_if #(.Res_Width(RW), .Addr_Width(AW)) bus ();
  ipf_res_buf #(.Res_Width(RW), .Depth(DP), .Addr_Width(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr, wrap, v;
    logic [15:0] d;
    logic        ds, rr;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic [2:0]  ec;
    logic        ef, eo, edn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic clr, wrap, v, input logic [15:0] d, input logic ds, rr,
                     input logic ev, input logic [15:0] ed, input logic el,
                     input logic [2:0] ec, input logic ef, eo, edn);
    vec_t t;
    t.clr = clr; t.wrap = wrap; t.v = v; t.d = d; t.ds = ds; t.rr = rr;
    t.ev = ev; t.ed = ed; t.el = el; t.ec = ec; t.ef = ef; t.eo = eo; t.edn = edn;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Packs observable outputs; rd_data only matters while rd_valid is expected.
  function automatic logic [31:0] pack(input logic v, input logic [15:0] d, input logic l,
                                       input logic p, input logic [2:0] c, input logic f,
                                       input logic o, input logic dn);
    return {7'd0, v, (v ? d : 16'h0000), l, p, c, f, o, dn};
  endfunction

  function automatic logic [31:0] act_pack();
    return pack(bus.rd_valid, bus.rd_data, bus.rd_last, bus.rd_perr, bus.count,
                bus.full, bus.ovf, bus.done);
  endfunction

  task automatic drive(input logic clr, wrap, v, input logic [15:0] d, input logic ds, rr);
    bus.clr = clr; bus.wrap_en = wrap; bus.res_valid = v; bus.res = d;
    bus.drain_start = ds; bus.rd_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] got[$];
    logic [15:0] prev_d;
    logic        prev_v, prev_l;
    logic        pat [7];

    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", act_pack(), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic: three words drained back to back
    add(0,0,1,16'h0011,0,0, 0,16'h0,0,3'd1,0,0,0);
    add(0,0,1,16'h0022,0,0, 0,16'h0,0,3'd2,0,0,0);
    add(0,0,1,16'h0033,0,0, 0,16'h0,0,3'd3,0,0,0);
    add(0,0,0,16'h0000,1,1, 0,16'h0,0,3'd3,0,0,0);
    add(0,0,0,16'h0000,0,1, 1,16'h0011,0,3'd3,0,0,0);
    add(0,0,0,16'h0000,0,1, 1,16'h0022,0,3'd2,0,0,0);
    add(0,0,0,16'h0000,0,1, 1,16'h0033,1,3'd1,0,0,0);
    add(0,0,0,16'h0000,0,1, 0,16'h0,0,3'd0,0,0,1);
    add(1,0,0,16'h0000,0,0, 0,16'h0,0,3'd0,0,0,0);
    // Drop mode: words 5 and 6 discarded
    add(0,0,1,16'h0001,0,0, 0,16'h0,0,3'd1,0,0,0);
    add(0,0,1,16'h0002,0,0, 0,16'h0,0,3'd2,0,0,0);
    add(0,0,1,16'h0003,0,0, 0,16'h0,0,3'd3,0,0,0);
    add(0,0,1,16'h0004,0,0, 0,16'h0,0,3'd4,1,0,0);
    add(0,0,1,16'h0005,0,0, 0,16'h0,0,3'd4,1,1,0);
    add(0,0,1,16'h0006,0,0, 0,16'h0,0,3'd4,1,1,0);
    add(0,0,0,16'h0000,1,1, 0,16'h0,0,3'd4,1,1,0);
    add(0,0,0,16'h0000,0,1, 1,16'h0001,0,3'd4,1,1,0);
    add(0,0,0,16'h0000,0,1, 1,16'h0002,0,3'd3,0,1,0);
    add(0,0,0,16'h0000,0,1, 1,16'h0003,0,3'd2,0,1,0);
    add(0,0,0,16'h0000,0,1, 1,16'h0004,1,3'd1,0,1,0);
    add(0,0,0,16'h0000,0,1, 0,16'h0,0,3'd0,0,1,1);
    add(1,0,0,16'h0000,0,0, 0,16'h0,0,3'd0,0,0,0);
    // Wrap mode: oldest words 1 and 2 overwritten
    add(0,1,1,16'h0001,0,0, 0,16'h0,0,3'd1,0,0,0);
    add(0,1,1,16'h0002,0,0, 0,16'h0,0,3'd2,0,0,0);
    add(0,1,1,16'h0003,0,0, 0,16'h0,0,3'd3,0,0,0);
    add(0,1,1,16'h0004,0,0, 0,16'h0,0,3'd4,1,0,0);
    add(0,1,1,16'h0005,0,0, 0,16'h0,0,3'd4,1,1,0);
    add(0,1,1,16'h0006,0,0, 0,16'h0,0,3'd4,1,1,0);
    add(0,1,0,16'h0000,1,1, 0,16'h0,0,3'd4,1,1,0);
    add(0,1,0,16'h0000,0,1, 1,16'h0003,0,3'd4,1,1,0);
    add(0,1,0,16'h0000,0,1, 1,16'h0004,0,3'd3,0,1,0);
    add(0,1,0,16'h0000,0,1, 1,16'h0005,0,3'd2,0,1,0);
    add(0,1,0,16'h0000,0,1, 1,16'h0006,1,3'd1,0,1,0);
    add(0,1,0,16'h0000,0,1, 0,16'h0,0,3'd0,0,1,1);
    add(1,0,0,16'h0000,0,0, 0,16'h0,0,3'd0,0,0,0);
    // Empty drain goes straight to done; drain_start in DONE ignored
    add(0,0,0,16'h0000,1,1, 0,16'h0,0,3'd0,0,0,1);
    add(0,0,0,16'h0000,1,1, 0,16'h0,0,3'd0,0,0,1);
    add(1,0,0,16'h0000,0,0, 0,16'h0,0,3'd0,0,0,0);
    // Same-cycle write and drain_start; write during DRAIN sets ovf; load ignores rd_ready
    add(0,0,1,16'hAAAA,0,0, 0,16'h0,0,3'd1,0,0,0);
    add(0,0,1,16'hBBBB,1,0, 0,16'h0,0,3'd2,0,0,0);
    add(0,0,0,16'h0000,0,0, 1,16'hAAAA,0,3'd2,0,0,0);
    add(0,0,1,16'hCCCC,0,0, 1,16'hAAAA,0,3'd2,0,1,0);
    add(0,0,0,16'h0000,0,1, 1,16'hBBBB,1,3'd1,0,1,0);
    add(0,0,0,16'h0000,0,1, 0,16'h0,0,3'd0,0,1,1);
    add(1,0,0,16'h0000,0,0, 0,16'h0,0,3'd0,0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].wrap, tbl[i].v, tbl[i].d, tbl[i].ds, tbl[i].rr);
      step();
      chk($sformatf("vec[%0d]", i), act_pack(),
          pack(tbl[i].ev, tbl[i].ed, tbl[i].el, 1'b0, tbl[i].ec, tbl[i].ef, tbl[i].eo,
               tbl[i].edn));
    end

    // Back-pressure: rd_ready pattern 1,0,0,1,1,0,1 over four entries
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1, 16'(16'h0101 * (k + 1)), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step();
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      prev_v = bus.rd_valid;
      prev_d = bus.rd_data;
      prev_l = bus.rd_last;
      bus.rd_ready = pat[k];
      step();
      if (pat[k] && prev_v) begin
        got.push_back(prev_d);
      end else begin
        chk($sformatf("bp_stall[%0d]", k), {bus.rd_valid, bus.rd_last, bus.rd_data},
            {prev_v, prev_l, prev_d});
      end
    end
    chk("bp_transfers", got.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_word[%0d]", k), (k < got.size()) ? {16'h0, got[k]} : 32'hFFFF_FFFF,
          32'(16'h0101 * (k + 1)));
    end
    chk("bp_done", {bus.done, bus.rd_valid}, 2'b10);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step();

    // Asynchronous reset in the middle of a drain
    drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 16'h5678, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step();
    chk("pre_rst_drain", act_pack(), pack(1'b1, 16'h1234, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0));
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {bus.rd_data, 16'h0} | act_pack(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
    step();
    chk("post_rst_fill", act_pack(), pack(1'b0, 16'h0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step();

`ifdef IPF_RES_BUF_PARITY_EN
    // Parity: corrupt the data bits of entry 1 only
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 16'(k), 1'b0, 1'b0);
      step();
    end
    force dut.mem_r[1] = 17'h1_0003;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("perr[%0d]", k), {bus.rd_valid, bus.rd_perr}, {1'b1, (k == 1)});
    end
    release dut.mem_r[1];
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
